// File: rtl/mmio_bridge.sv
// mmio_bridge: routes CPU accesses to RAM or I/O (UART TX FIFO, RX pop, cycle counter, stop flag)
module mmio_bridge #(
    parameter int TX_DEPTH_LOG2 = 3,
    parameter int RAM_ADDR_W    = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [31:0]           cpu_a,
    input  logic [7:0]            cpu_dout,
    input  logic                  cpu_wr,
    output logic [7:0]            cpu_din,
    output logic                  cpu_rdy,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [7:0]            ram_dout,
    output logic                  ram_we,
    input  logic [7:0]            ram_din,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic                  tx_busy,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_pop,
    output logic                  program_stop
);
    localparam int DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int PW    = TX_DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        SRC_ZERO, SRC_RAM, SRC_RX, SRC_CNT0, SRC_CNT1, SRC_CNT2, SRC_CNT3
    } src_e;

    logic          cpu_rdy_q, cpu_rdy_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, tx_count, tx_free;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [31:0]   cnt_q, cnt_d, snap_q, snap_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    src_e          sel_q, sel_d;
    logic          stop_pending_q, stop_pending_d, stop_q, stop_d;
    logic          acc_rd, acc_wr, hit_data, hit_ctrl, hit_cnt;
    logic          tx_full, tx_empty, tx_push_req, tx_push, tx_pop;
    logic [7:0]    push_byte;
    logic          unused_hi;

    assign unused_hi    = ^cpu_a[31:18];
    assign ram_a        = cpu_a[RAM_ADDR_W-1:0];
    assign ram_dout     = cpu_dout;
    assign ram_we       = cpu_wr & ~cpu_a[17];
    assign tx_data      = mem_q[rptr_q[TX_DEPTH_LOG2-1:0]];
    assign tx_valid     = ~tx_empty;
    assign cpu_rdy      = cpu_rdy_q;
    assign program_stop = stop_q;
    assign rx_pop       = rst_in & acc_rd & hit_data & rx_valid;

    // Address decode and FIFO status; the bus is only honoured while cpu_rdy is high
    always_comb begin
        hit_data    = cpu_a[17:0] == 18'h30000;
        hit_ctrl    = cpu_a[17:0] == 18'h30004;
        hit_cnt     = cpu_a[17:2] == 16'hC001;
        acc_rd      = cpu_rdy_q & ~cpu_wr;
        acc_wr      = cpu_rdy_q & cpu_wr;
        tx_count    = wptr_q - rptr_q;
        tx_free     = PW'(DEPTH) - tx_count;
        tx_empty    = wptr_q == rptr_q;
        tx_full     = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
        tx_push_req = acc_wr & (hit_ctrl | (hit_data & (cpu_dout != 8'h00)));
        tx_push     = tx_push_req & ~tx_full;
        tx_pop      = tx_valid & tx_ready;
        push_byte   = hit_ctrl ? 8'h00 : cpu_dout;
    end

    // Next-state: FIFO, throttle, counter/snapshot, read source and stop tracking
    always_comb begin
        mem_d = mem_q;
        if (tx_push) mem_d[wptr_q[TX_DEPTH_LOG2-1:0]] = push_byte;
        wptr_d         = wptr_q + PW'(tx_push);
        rptr_d         = rptr_q + PW'(tx_pop);
        cpu_rdy_d      = tx_free >= PW'(3);
        cnt_d          = cnt_q + 32'd1;
        snap_d         = (acc_rd & hit_ctrl) ? cnt_q : snap_q;
        rx_byte_d      = rx_pop ? rx_data : (acc_rd & hit_data) ? 8'h00 : rx_byte_q;
        sel_d          = !acc_rd ? SRC_ZERO :
                         !cpu_a[17] ? SRC_RAM :
                         hit_data ? SRC_RX :
                         !hit_cnt ? SRC_ZERO :
                         cpu_a[1:0] == 2'd0 ? SRC_CNT0 :
                         cpu_a[1:0] == 2'd1 ? SRC_CNT1 :
                         cpu_a[1:0] == 2'd2 ? SRC_CNT2 : SRC_CNT3;
        stop_pending_d = stop_pending_q | (acc_wr & hit_ctrl);
        stop_d         = stop_q | (stop_pending_q & tx_empty & ~tx_busy & ~tx_valid);
    end

    // Read data mux for the access captured on the previous edge
    always_comb begin
        cpu_din = sel_q == SRC_RAM  ? ram_din :
                  sel_q == SRC_RX   ? rx_byte_q :
                  sel_q == SRC_CNT0 ? snap_q[7:0] :
                  sel_q == SRC_CNT1 ? snap_q[15:8] :
                  sel_q == SRC_CNT2 ? snap_q[23:16] :
                  sel_q == SRC_CNT3 ? snap_q[31:24] : 8'h00;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mem_q          <= '{default: 8'h00};
            wptr_q         <= '0;
            rptr_q         <= '0;
            cpu_rdy_q      <= 1'b1;
            cnt_q          <= '0;
            snap_q         <= '0;
            rx_byte_q      <= '0;
            sel_q          <= SRC_ZERO;
            stop_pending_q <= 1'b0;
            stop_q         <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            cpu_rdy_q      <= cpu_rdy_d;
            cnt_q          <= cnt_d;
            snap_q         <= snap_d;
            rx_byte_q      <= rx_byte_d;
            sel_q          <= sel_d;
            stop_pending_q <= stop_pending_d;
            stop_q         <= stop_d;
        end
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: scoreboard bench for the CPU memory/I/O bridge
module tb_mmio_bridge;
    logic        clk_in = 1'b0, rst_in = 1'b0;
    logic [31:0] cpu_a = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0, tx_busy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_pop;
    logic        program_stop;

    int          checks = 0, errors = 0;
    logic [7:0]  rd_exp[$];
    logic [7:0]  tx_exp[$];
    logic        rd_inflight = 1'b0;
    logic [7:0]  ram_mem [0:131071];

    mmio_bridge dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .cpu_rdy(cpu_rdy), .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we),
        .ram_din(ram_din), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .program_stop(program_stop)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_dout;
        ram_din <= ram_mem[ram_a];
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        logic [7:0] e;
        #1;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            checks++;
            if (tx_exp.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got %h want none", tx_data);
            end else begin
                e = tx_exp.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_data got %h want %h", tx_data, e);
                end
            end
        end
        if (dut.tx_push_req === 1'b1) begin
            checks++;
            if (dut.tx_full !== 1'b0) begin
                errors++;
                $display("FAIL push_when_full got full=%b want 0", dut.tx_full);
            end
        end
        @(negedge clk_in);
        if (rd_inflight) begin
            rd_inflight = 1'b0;
            e = rd_exp.pop_front();
            checks++;
            if (cpu_din !== e) begin
                errors++;
                $display("FAIL rd_data got %h want %h", cpu_din, e);
            end
        end
    endtask

    task automatic idle();
        cpu_a = '0;
        cpu_wr = 1'b0;
        cpu_dout = '0;
    endtask

    task automatic issue(input logic [31:0] a, input logic wr, input logic [7:0] d,
                         input logic rd_chk, input logic [7:0] exp);
        int n = 0;
        cpu_a = a;
        cpu_wr = wr;
        cpu_dout = d;
        while (cpu_rdy !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (n == 100) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout got rdy=%b want 1", cpu_rdy);
        end
        if (!wr && rd_chk) begin
            rd_exp.push_back(exp);
            rd_inflight = 1'b1;
        end
        step();
    endtask

    task automatic drain();
        int n = 0;
        while (tx_exp.size() != 0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (tx_exp.size() != 0) begin
            errors++;
            $display("FAIL tx_drain got %0d left want 0", tx_exp.size());
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        idle();
        repeat (2) step();
        checks += 5;
        if (cpu_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", cpu_din); end
        if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", cpu_rdy); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txv got %b want 0", tx_valid); end
        if (rx_pop !== 1'b0) begin errors++; $display("FAIL reset_rxpop got %b want 0", rx_pop); end
        if (program_stop !== 1'b0) begin errors++; $display("FAIL reset_stop got %b want 0", program_stop); end
        rst_in = 1'b1;
        repeat (4) step();
        issue(32'h30004, 1'b0, 8'h00, 1'b1, 8'h04);
        issue(32'h30005, 1'b0, 8'h00, 1'b1, 8'h00);
        idle();
    endtask

    task automatic test_ram();
        cpu_a = 32'h00123;
        cpu_wr = 1'b1;
        cpu_dout = 8'hA5;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_a !== 17'h00123 || ram_dout !== 8'hA5) begin
            errors++;
            $display("FAIL ram_write got we=%b a=%h d=%h want 1 00123 a5", ram_we, ram_a, ram_dout);
        end
        step();
        issue(32'h00123, 1'b0, 8'h00, 1'b1, 8'hA5);
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_we_pulse got %b want 0", ram_we); end
        issue(32'h1FFFF, 1'b1, 8'h3C, 1'b0, 8'h00);
        issue(32'h1FFFF, 1'b0, 8'h00, 1'b1, 8'h3C);
        cpu_a = 32'h30000;
        cpu_wr = 1'b1;
        cpu_dout = 8'h00;
        #1;
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_we_io got %b want 0", ram_we); end
        step();
        idle();
    endtask

    task automatic test_tx_stream();
        tx_ready = 1'b1;
        tx_exp.push_back(8'h48);
        tx_exp.push_back(8'h69);
        issue(32'h30000, 1'b1, 8'h48, 1'b0, 8'h00);
        issue(32'h30000, 1'b1, 8'h00, 1'b0, 8'h00);
        issue(32'h30000, 1'b1, 8'h69, 1'b0, 8'h00);
        idle();
        drain();
        step();
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_idle got %b want 0", tx_valid); end
    endtask

    task automatic test_back_pressure();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) tx_exp.push_back(8'h41 + 8'(i));
        for (int i = 0; i < 6; i++) issue(32'h30000, 1'b1, 8'h41 + 8'(i), 1'b0, 8'h00);
        checks++;
        if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy6 got %b want 1", cpu_rdy); end
        issue(32'h30000, 1'b1, 8'h47, 1'b0, 8'h00);
        checks++;
        if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy7 got %b want 0", cpu_rdy); end
        cpu_a = 32'h30000;
        cpu_wr = 1'b1;
        cpu_dout = 8'h48;
        repeat (3) step();
        checks++;
        if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL bp_hold got %b want 0", cpu_rdy); end
        tx_ready = 1'b1;
        issue(32'h30000, 1'b1, 8'h48, 1'b0, 8'h00);
        idle();
        drain();
        step();
        checks++;
        if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_back got %b want 1", cpu_rdy); end
    endtask

    task automatic test_rx_read();
        rx_valid = 1'b1;
        rx_data = 8'h37;
        cpu_a = 32'h30000;
        cpu_wr = 1'b0;
        #1;
        checks++;
        if (rx_pop !== 1'b1) begin errors++; $display("FAIL rx_pop_on got %b want 1", rx_pop); end
        rd_exp.push_back(8'h37);
        rd_inflight = 1'b1;
        step();
        idle();
        #1;
        checks++;
        if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pop_off got %b want 0", rx_pop); end
        rx_valid = 1'b0;
        rx_data = 8'h99;
        cpu_a = 32'h30000;
        #1;
        checks++;
        if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pop_empty got %b want 0", rx_pop); end
        rd_exp.push_back(8'h00);
        rd_inflight = 1'b1;
        step();
        issue(32'h30008, 1'b0, 8'h00, 1'b1, 8'h00);
        issue(32'h20000, 1'b0, 8'h00, 1'b1, 8'h00);
        idle();
    endtask

    task automatic test_counter();
        force dut.cnt_q = 32'h000000FE;
        issue(32'h30004, 1'b0, 8'h00, 1'b1, 8'hFE);
        release dut.cnt_q;
        issue(32'h30005, 1'b0, 8'h00, 1'b1, 8'h00);
        issue(32'h30006, 1'b0, 8'h00, 1'b1, 8'h00);
        issue(32'h30007, 1'b0, 8'h00, 1'b1, 8'h00);
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        checks++;
        if (dut.cnt_d !== 32'h0) begin errors++; $display("FAIL cnt_wrap got %h want 00000000", dut.cnt_d); end
        issue(32'h30004, 1'b0, 8'h00, 1'b1, 8'hFF);
        issue(32'h30007, 1'b0, 8'h00, 1'b1, 8'hFF);
        release dut.cnt_q;
        idle();
    endtask

    task automatic test_stop();
        tx_ready = 1'b0;
        tx_busy = 1'b0;
        tx_exp.push_back(8'h00);
        issue(32'h30004, 1'b1, 8'h5A, 1'b0, 8'h00);
        idle();
        repeat (3) step();
        checks += 2;
        if (program_stop !== 1'b0) begin errors++; $display("FAIL stop_fifo got %b want 0", program_stop); end
        if (tx_valid !== 1'b1) begin errors++; $display("FAIL stop_txv got %b want 1", tx_valid); end
        tx_busy = 1'b1;
        tx_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (program_stop !== 1'b0) begin errors++; $display("FAIL stop_busy got %b want 0", program_stop); end
        tx_busy = 1'b0;
        step();
        checks++;
        if (program_stop !== 1'b1) begin errors++; $display("FAIL stop_set got %b want 1", program_stop); end
        tx_busy = 1'b1;
        repeat (2) step();
        checks++;
        if (program_stop !== 1'b1) begin errors++; $display("FAIL stop_sticky got %b want 1", program_stop); end
        tx_busy = 1'b0;
        tx_exp.push_back(8'h7E);
        issue(32'h30000, 1'b1, 8'h7E, 1'b0, 8'h00);
        idle();
        drain();
    endtask

    task automatic test_reset_midstream();
        tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) issue(32'h30000, 1'b1, 8'h61 + 8'(i), 1'b0, 8'h00);
        checks++;
        if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL mid_rdy_low got %b want 0", cpu_rdy); end
        idle();
        rst_in = 1'b0;
        step();
        checks += 4;
        if (program_stop !== 1'b0) begin errors++; $display("FAIL mid_stop got %b want 0", program_stop); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_txv got %b want 0", tx_valid); end
        if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy got %b want 1", cpu_rdy); end
        if (cpu_din !== 8'h00) begin errors++; $display("FAIL mid_din got %h want 00", cpu_din); end
        rst_in = 1'b1;
        tx_ready = 1'b1;
        repeat (5) step();
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_empty got %b want 0", tx_valid); end
        tx_exp.push_back(8'h5B);
        issue(32'h30000, 1'b1, 8'h5B, 1'b0, 8'h00);
        idle();
        drain();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx_stream();
        test_back_pressure();
        test_rx_read();
        test_counter();
        test_stop();
        test_reset_midstream();
        checks++;
        if (rd_exp.size() != 0 || tx_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got rd=%0d tx=%0d want 0 0", rd_exp.size(), tx_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits directly downstream of the CPU memory bus (address, write data, write flag, read data, ready).
- Decodes each access by address bit 17 and routes it to one of two targets:
  - bit 17 = 0: the 128KB synchronous RAM.
  - bit 17 = 1: the I/O space.
- The I/O space holds a UART TX FIFO, the UART RX pop port, a free-running cycle counter and the program-stop indicator.
- Returns read data with the same fixed timing for RAM and I/O.
- Throttles the CPU through its ready input when the TX FIFO nears full.

Parameters:
- TX_DEPTH_LOG2, 3, log2 of TX FIFO depth (8 entries).
- RAM_ADDR_W, 17, RAM address width (128KB).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-low reset.
- cpu_a  in  32  CPU byte address; only bits 17:0 are decoded.
- cpu_dout  in  8  CPU write data.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_din  out  8  read data returned to the CPU.
- cpu_rdy  out  1  drives the CPU rdy_in; low pauses the CPU.
- ram_a  out  RAM_ADDR_W  RAM address.
- ram_dout  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_din  in  8  RAM read data, valid one cycle after the address.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- tx_busy  in  1  transmitter is shifting a byte.
- rx_data  in  8  head byte of the UART receive buffer.
- rx_valid  in  1  rx_data valid.
- rx_pop  out  1  one-cycle pulse that consumes rx_data.
- program_stop  out  1  sticky; asserted when the program has ended and the stop byte has left the transmitter.

Behaviour:
- Reset (rst_in == 0 at a clock edge) sets:
  - cpu_din = 0, cpu_rdy = 1;
  - tx_valid = 0, rx_pop = 0, program_stop = 0;
  - TX FIFO empty, cycle counter = 0, snapshot = 0, stop_pending = 0.
  - Reset in the middle of a transfer discards all FIFO contents and any pending read.
- RAM path (cpu_a[17] == 0), combinational:
  - ram_a = cpu_a[16:0], ram_dout = cpu_dout.
  - ram_we = cpu_wr & ~cpu_a[17].
  - RAM writes complete in 1 cycle.
- Read timing:
  - Address presented in cycle N; cpu_din is valid during cycle N+1.
  - A registered source selector (RAM, RX, or counter byte 0..3), captured in cycle N, muxes ram_din or the registered I/O byte in cycle N+1.
- I/O reads:
  - 0x30000: if rx_valid, rx_pop = 1 for exactly cycle N and rx_data is registered; otherwise the returned byte is 0x00 and there is no pop.
  - 0x30004: the full 32-bit counter is latched into the snapshot register, and byte 0 is returned.
  - 0x30005, 0x30006, 0x30007: return snapshot bytes 1, 2, 3. The four bytes are therefore coherent.
  - Any other I/O address returns 0x00.
- I/O writes:
  - 0x30000 with a nonzero byte: pushed into the TX FIFO.
  - 0x30000 with 0x00: ignored.
  - 0x30004 (any data): pushes 0x00 into the TX FIFO and sets stop_pending.
  - Other I/O addresses: ignored.
- TX FIFO:
  - Circular buffer with TX_DEPTH_LOG2+1 bit pointers; full and empty are distinguished by the MSB.
  - Head byte drives tx_data; tx_valid = !empty.
  - A pop occurs when tx_valid & tx_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - A push when full is dropped. This cannot occur under correct throttling; the bench asserts it never happens.
- Throttle:
  - cpu_rdy is registered.
  - It falls the cycle after the free count drops to ≤ 2 and rises the cycle after the free count returns to ≥ 3.
  - This guarantees that a write already in flight when cpu_rdy falls is accepted.
  - The bridge ignores all cpu_* inputs while cpu_rdy == 0.
- Cycle counter:
  - 32-bit, increments every clock after reset regardless of cpu_rdy.
  - Wraps from 0xFFFFFFFF to 0.
- Stop:
  - program_stop is set when stop_pending & FIFO empty & !tx_busy & !tx_valid.
  - Once set, it stays set until reset.
  - Writes after stop_pending are still processed.

Test Plan:
- RAM path: write 0xA5 to 0x00123, then read 0x00123 → ram_we is high for 1 cycle with ram_a = 0x00123; cpu_din = 0xA5 in the cycle after the read address.
- TX stream: write 0x48, 0x00, 0x69 to 0x30000 with tx_ready held 1 → tx_data sequence is 0x48, 0x69; the 0x00 is never enqueued.
- Back-pressure: tx_ready = 0 and 8 back-to-back writes of 0x41..0x48 → cpu_rdy falls after the 6th push; no byte is lost; after releasing tx_ready all 8 bytes emerge in order.
- RX read:
  - rx_valid = 1, rx_data = 0x37, read 0x30000 → rx_pop is a single 1-cycle pulse; cpu_din = 0x37 next cycle.
  - Repeat with rx_valid = 0 → cpu_din = 0x00 and no pop.
- Counter coherency:
  - Preload the counter at 0x000000FE, then read 0x30004..0x30007 on consecutive cycles → bytes 0xFE, 0x00, 0x00, 0x00 (the snapshot is unaffected by the carry).
  - Separately, the counter at 0xFFFFFFFF wraps to 0.
- Stop and reset:
  - Write 0x30004 with tx_busy pulsed for 10 cycles → 0x00 is emitted on tx_data, and program_stop rises once the FIFO is empty and tx_busy is low.
  - Asserting rst_in = 0 mid-stream clears program_stop, empties the FIFO and sets cpu_rdy = 1 on the next edge.
